// File: rtl/time_set_pkg.sv
// ============================================================================
// Module      : time_set_pkg
// Description : Shared types, field codes and helpers for the RTC time-set
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_set_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_HH   = 2'd0;
    localparam logic [1:0] FIELD_MM   = 2'd1;
    localparam logic [1:0] FIELD_SS   = 2'd2;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    // Bit positions of the buttons in the packed button vector
    localparam int BTN_CFG   = 4;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 1;
    localparam int BTN_DN    = 0;

    // Bits needed for a counter running 0 .. n-1
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] field_of(input state_e s);
        case (s)
            SET_HH:  return FIELD_HH;
            SET_MM:  return FIELD_MM;
            SET_SS:  return FIELD_SS;
            default: return FIELD_NONE;
        endcase
    endfunction

    function automatic state_e next_right(input state_e s);
        case (s)
            SET_HH:  return SET_MM;
            SET_MM:  return SET_SS;
            SET_SS:  return SET_HH;
            default: return s;
        endcase
    endfunction

    function automatic state_e next_left(input state_e s);
        case (s)
            SET_HH:  return SET_SS;
            SET_SS:  return SET_MM;
            SET_MM:  return SET_HH;
            default: return s;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
// ============================================================================
// Module      : time_set_ctrl_if
// Description : Button inputs and field-counter control outputs of the
//               time-set controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface time_set_ctrl_if;
    logic       btn_cfg;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       up_hh;
    logic       dn_hh;
    logic       up_mm;
    logic       dn_mm;
    logic       up_ss;
    logic       dn_ss;
    logic [1:0] field_sel;
    logic       edit_active;
    logic       run_en;
    logic       blink;

    modport master (
        output btn_cfg, btn_left, btn_right, btn_up, btn_down,
        input  up_hh, dn_hh, up_mm, dn_mm, up_ss, dn_ss,
        input  field_sel, edit_active, run_en, blink
    );

    modport slave (
        input  btn_cfg, btn_left, btn_right, btn_up, btn_down,
        output up_hh, dn_hh, up_mm, dn_mm, up_ss, dn_ss,
        output field_sel, edit_active, run_en, blink
    );
endinterface

`default_nettype wire

// File: rtl/time_set_ctrl_edge_tick.sv
// ============================================================================
// Module      : edge_tick
// Description : Rising-edge detector for one debounced button; history resets
//               high so a button held through reset gives no tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_tick (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic tick_o,
    output logic level_o
);
    logic sample_q;
    logic hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q <= 1'b1;
            hist_q   <= 1'b1;
        end else begin
            sample_q <= btn_i;
            hist_q   <= sample_q;
        end
    end

    assign tick_o  = sample_q & ~hist_q;
    assign level_o = sample_q;
endmodule

`default_nettype wire

// File: rtl/time_set_ctrl.sv
// ============================================================================
// Module      : time_set_ctrl
// Description : RTC edit-mode controller: field-select FSM, up/down pulse
//               steering, edit timeout and field blink. Optional auto-repeat
//               of held up/down buttons when AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int BLINK_CYCLES   = 25_000_000,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_RATE    = 10_000_000
) (
    input  logic            clk,
    input  logic            reset,
    time_set_ctrl_if.slave  bus
);
    localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int BL_W = cnt_width(BLINK_CYCLES);

    logic [4:0] btn_raw;
    logic [4:0] tick;
    logic [4:0] level;

    assign btn_raw = {bus.btn_cfg, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};

    generate
        for (genvar i = 0; i < 5; i++) begin : g_edge
            edge_tick u_edge (
                .clk     (clk),
                .reset   (reset),
                .btn_i   (btn_raw[i]),
                .tick_o  (tick[i]),
                .level_o (level[i])
            );
        end
    endgenerate

    logic cfg_tick, left_tick, right_tick, up_tick, dn_tick;
    assign cfg_tick   = tick[BTN_CFG];
    assign left_tick  = tick[BTN_LEFT];
    assign right_tick = tick[BTN_RIGHT];
    assign up_tick    = tick[BTN_UP];
    assign dn_tick    = tick[BTN_DN];

    state_e          state_q, state_d;
    logic            accept, press_up, press_dn, pulse_up, pulse_dn;
    logic            rep_fire, rep_up;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_hit;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            blink_q, blink_d;
    logic [5:0]      pulse_q, pulse_d;
    logic [1:0]      fsel_q, fsel_d;
    logic            edit_q, edit_d;
    logic            run_q, run_d;

    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // cfg beats navigation beats up/down; a losing tick is dropped
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        press_up = 1'b0;
        press_dn = 1'b0;
        pulse_up = 1'b0;
        pulse_dn = 1'b0;
        if (cfg_tick) begin
            state_d = (state_q == RUN) ? SET_HH : RUN;
            accept  = 1'b1;
        end else if (state_q != RUN) begin
            if (left_tick | right_tick) begin
                if (left_tick ^ right_tick) begin
                    state_d = right_tick ? next_right(state_q) : next_left(state_q);
                    accept  = 1'b1;
                end
            end else if (up_tick ^ dn_tick) begin
                press_up = up_tick;
                press_dn = dn_tick;
                pulse_up = up_tick;
                pulse_dn = dn_tick;
                accept   = 1'b1;
            end else if (rep_fire) begin
                pulse_up = rep_up;
                pulse_dn = ~rep_up;
                accept   = 1'b1;
            end
            if (!accept && to_hit) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        pulse_d = 6'b0;
        case (state_q)
            SET_HH:  pulse_d = {pulse_up, pulse_dn, 4'b0};
            SET_MM:  pulse_d = {2'b0, pulse_up, pulse_dn, 2'b0};
            SET_SS:  pulse_d = {4'b0, pulse_up, pulse_dn};
            default: pulse_d = 6'b0;
        endcase
        fsel_d = field_of(state_d);
        edit_d = (state_d != RUN);
        run_d  = (state_d == RUN);

        if (!edit_d || accept) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        // Entry and field changes restart the blink phase with the field visible
        if (!edit_d || (state_d != state_q)) begin
            bl_cnt_d = '0;
            blink_d  = 1'b1;
        end else if (bl_cnt_q == BL_W'(BLINK_CYCLES - 1)) begin
            bl_cnt_d = '0;
            blink_d  = ~blink_q;
        end else begin
            bl_cnt_d = bl_cnt_q + BL_W'(1);
            blink_d  = blink_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q  <= 6'b0;
            fsel_q   <= FIELD_NONE;
            edit_q   <= 1'b0;
            run_q    <= 1'b1;
            blink_q  <= 1'b1;
            to_cnt_q <= '0;
            bl_cnt_q <= '0;
        end else begin
            pulse_q  <= pulse_d;
            fsel_q   <= fsel_d;
            edit_q   <= edit_d;
            run_q    <= run_d;
            blink_q  <= blink_d;
            to_cnt_q <= to_cnt_d;
            bl_cnt_q <= bl_cnt_d;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W    = cnt_width(REP_MAX);

    logic            rep_act_q, rep_act_d;
    logic            rep_up_q, rep_up_d;
    logic            rep_first_q, rep_first_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            held, other, rep_stop;

    assign held     = rep_up_q ? level[BTN_UP] : level[BTN_DN];
    assign other    = rep_up_q ? level[BTN_DN] : level[BTN_UP];
    assign rep_stop = cfg_tick | left_tick | right_tick | (state_q == RUN) | ~held | other;
    assign rep_fire = rep_act_q & ~rep_stop &
                      (rep_cnt_q == (rep_first_q ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_RATE - 1)));
    assign rep_up   = rep_up_q;

    always_comb begin
        rep_act_d   = rep_act_q;
        rep_up_d    = rep_up_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        if (press_up | press_dn) begin
            rep_act_d   = 1'b1;
            rep_up_d    = press_up;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end else if (!rep_act_q || rep_stop) begin
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
        end else if (rep_fire) begin
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
        end else begin
            rep_cnt_d = rep_cnt_q + RP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_act_q   <= 1'b0;
            rep_up_q    <= 1'b0;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
        end else begin
            rep_act_q   <= rep_act_d;
            rep_up_q    <= rep_up_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    logic unused_levels;
    assign unused_levels = ^level[4:2];
`else
    assign rep_fire = 1'b0;
    assign rep_up   = 1'b0;

    logic unused_repeat;
    assign unused_repeat = ^{level, 32'(REPEAT_DELAY), 32'(REPEAT_RATE), press_up, press_dn};
`endif

    assign bus.up_hh       = pulse_q[5];
    assign bus.dn_hh       = pulse_q[4];
    assign bus.up_mm       = pulse_q[3];
    assign bus.dn_mm       = pulse_q[2];
    assign bus.up_ss       = pulse_q[1];
    assign bus.dn_ss       = pulse_q[0];
    assign bus.field_sel   = fsel_q;
    assign bus.edit_active = edit_q;
    assign bus.run_en      = run_q;
    assign bus.blink       = blink_q;
endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Self-checking bench for time_set_ctrl (vector table plus
//               hand-written repeat and reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_set_ctrl;
    localparam int NV = 77;
    localparam logic [4:0] B_0   = 5'b00000;
    localparam logic [4:0] B_CFG = 5'b10000;
    localparam logic [4:0] B_L   = 5'b01000;
    localparam logic [4:0] B_R   = 5'b00100;
    localparam logic [4:0] B_U   = 5'b00010;
    localparam logic [4:0] B_D   = 5'b00001;
    localparam logic [5:0] P_0   = 6'b000000;
    localparam logic [5:0] P_UHH = 6'b100000;
    localparam logic [5:0] P_USS = 6'b000010;
    localparam logic [5:0] P_DSS = 6'b000001;

    logic clk;
    logic reset;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .TIMEOUT_CYCLES (40),
        .BLINK_CYCLES   (4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  btn;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [NV];
    int   n_chk;
    int   n_fail;

    function automatic vec_t mk(input logic [4:0] b, input logic [5:0] p,
                                input logic [1:0] fs, input logic bl);
        vec_t v;
        v.btn = b;
        v.exp = {p, fs, (fs != 2'd3), (fs == 2'd3), bl};
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {bus.up_hh, bus.dn_hh, bus.up_mm, bus.dn_mm, bus.up_ss, bus.dn_ss,
                bus.field_sel, bus.edit_active, bus.run_en, bus.blink};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] b);
        bus.btn_cfg   = b[4];
        bus.btn_left  = b[3];
        bus.btn_right = b[2];
        bus.btn_up    = b[1];
        bus.btn_down  = b[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ep;
        n_chk  = 0;
        n_fail = 0;

        vecs[0]  = mk(B_U,  P_0,   2'd3, 1'b1);
        vecs[1]  = mk(B_0,  P_0,   2'd3, 1'b1);
        vecs[2]  = mk(B_CFG,P_0,   2'd3, 1'b1);
        vecs[3]  = mk(B_0,  P_0,   2'd0, 1'b1);
        vecs[4]  = mk(B_U,  P_0,   2'd0, 1'b1);
        vecs[5]  = mk(B_0,  P_UHH, 2'd0, 1'b1);
        vecs[6]  = mk(B_U,  P_0,   2'd0, 1'b1);
        vecs[7]  = mk(B_0,  P_UHH, 2'd0, 1'b0);
        vecs[8]  = mk(B_U,  P_0,   2'd0, 1'b0);
        vecs[9]  = mk(B_0,  P_UHH, 2'd0, 1'b0);
        vecs[10] = mk(B_0,  P_0,   2'd0, 1'b0);
        vecs[11] = mk(B_0,  P_0,   2'd0, 1'b1);
        vecs[12] = mk(B_R,  P_0,   2'd0, 1'b1);
        vecs[13] = mk(B_0,  P_0,   2'd1, 1'b1);
        vecs[14] = mk(B_R,  P_0,   2'd1, 1'b1);
        vecs[15] = mk(B_0,  P_0,   2'd2, 1'b1);
        vecs[16] = mk(B_R,  P_0,   2'd2, 1'b1);
        vecs[17] = mk(B_0,  P_0,   2'd0, 1'b1);
        vecs[18] = mk(B_L,  P_0,   2'd0, 1'b1);
        vecs[19] = mk(B_0,  P_0,   2'd2, 1'b1);
        vecs[20] = mk(B_U | B_D, P_0, 2'd2, 1'b1);
        vecs[21] = mk(B_0,  P_0,   2'd2, 1'b1);
        vecs[22] = mk(B_0,  P_0,   2'd2, 1'b1);
        vecs[23] = mk(B_0,  P_0,   2'd2, 1'b0);
        vecs[24] = mk(B_CFG,P_0,   2'd2, 1'b0);
        vecs[25] = mk(B_0,  P_0,   2'd3, 1'b1);
        vecs[26] = mk(B_CFG,P_0,   2'd3, 1'b1);
        vecs[27] = mk(B_0,  P_0,   2'd0, 1'b1);
        vecs[28] = mk(B_R | B_U, P_0, 2'd0, 1'b1);
        vecs[29] = mk(B_0,  P_0,   2'd1, 1'b1);
        vecs[30] = mk(B_0,  P_0,   2'd1, 1'b1);
        vecs[31] = mk(B_0,  P_0,   2'd1, 1'b1);
        vecs[32] = mk(B_0,  P_0,   2'd1, 1'b1);
        vecs[33] = mk(B_0,  P_0,   2'd1, 1'b0);
        vecs[34] = mk(B_R,  P_0,   2'd1, 1'b0);
        vecs[35] = mk(B_0,  P_0,   2'd2, 1'b1);
        // Idle in SET_SS after the field change at row 35 until the 40-cycle timeout
        for (int r = 36; r <= 74; r++) begin
            vecs[r] = mk(B_0, P_0, 2'd2, (((r - 35) / 4) % 2) == 0);
        end
        vecs[75] = mk(B_0,  P_0,   2'd3, 1'b1);
        vecs[76] = mk(B_0,  P_0,   2'd3, 1'b1);

        reset = 1'b1;
        drive(B_U);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {5'b0, outs()}, {5'b0, 6'b0, 2'd3, 1'b0, 1'b1, 1'b1});
        reset = 1'b0;

        for (int r = 0; r < NV; r++) begin
            drive(vecs[r].btn);
            step();
            check($sformatf("row%0d", r), {5'b0, outs()}, {5'b0, vecs[r].exp});
        end

        // Enter SET_SS via cfg then left
        drive(B_CFG); step();
        drive(B_0);   step();
        check("enter_hh", {13'b0, bus.field_sel, bus.edit_active}, {13'b0, 2'd0, 1'b1});
        drive(B_L);   step();
        drive(B_0);   step();
        check("left_to_ss", {8'b0, outs()[10:3]}, {8'b0, P_0, 2'd2});
        step();

        for (int i = 0; i <= 24; i++) begin
            drive((i < 20) ? B_D : B_0);
            step();
`ifdef AUTOREPEAT_EN
            ep = (i == 1 || i == 11 || i == 14 || i == 17 || i == 20) ? P_DSS : P_0;
`else
            ep = (i == 1) ? P_DSS : P_0;
`endif
            check($sformatf("hold_dn%0d", i), {8'b0, outs()[10:3]}, {8'b0, ep, 2'd2});
        end

        drive(B_U); step();
        drive(B_0); step();
        check("up_ss", {7'b0, outs()[10:2]}, {7'b0, P_USS, 2'd2, 1'b1});
        reset = 1'b1;
        #1;
        check("async_reset", {5'b0, outs()}, {5'b0, 6'b0, 2'd3, 1'b0, 1'b1, 1'b1});
        #3;
        reset = 1'b0;
        step();
        check("post_reset", {5'b0, outs()}, {5'b0, 6'b0, 2'd3, 1'b0, 1'b1, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
